// File: rtl/dmem_pkg.sv
// dmem_pkg: shared funct3 encodings and FSM state type for the data-memory responder.
`default_nettype none

package dmem_pkg;

  localparam logic [2:0] FUNCT3_LB  = 3'd0;
  localparam logic [2:0] FUNCT3_LH  = 3'd1;
  localparam logic [2:0] FUNCT3_LW  = 3'd2;
  localparam logic [2:0] FUNCT3_LBU = 3'd4;
  localparam logic [2:0] FUNCT3_LHU = 3'd5;

  localparam logic [2:0] FUNCT3_SB  = 3'd0;
  localparam logic [2:0] FUNCT3_SH  = 3'd1;
  localparam logic [2:0] FUNCT3_SW  = 3'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_responder_if.sv
// dmem_if: request/response handshake bundle between the core and the data-memory responder.
`default_nettype none

interface dmem_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [AWIDTH-1:0] req_addr_i;
  logic [DWIDTH-1:0] req_wdata_i;
  logic [2:0]        req_funct3_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DWIDTH-1:0] rsp_rdata_o;
  logic              rsp_err_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_funct3_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_funct3_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
endinterface

`default_nettype wire

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-lane steering for stores, load extraction/extension, and access legality flags.
`default_nettype none

module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic        we,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_sh,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        illegal
);

  logic [31:0] shifted;

  always_comb begin
    shifted   = rword >> {addr_lo, 3'b000};
    load_data = '0;
    byte_en   = 4'b0000;
    wdata_sh  = wdata << {addr_lo, 3'b000};

    case (funct3)
      FUNCT3_LB:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      FUNCT3_LH:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      FUNCT3_LW:  load_data = shifted;
      FUNCT3_LBU: load_data = {24'd0, shifted[7:0]};
      FUNCT3_LHU: load_data = {16'd0, shifted[15:0]};
      default:    load_data = '0;
    endcase

    case (funct3)
      FUNCT3_SB: byte_en = 4'b0001 << addr_lo;
      FUNCT3_SH: byte_en = 4'b0011 << addr_lo;
      FUNCT3_SW: byte_en = 4'b1111;
      default:   byte_en = 4'b0000;
    endcase

    // funct3[1:0] encodes size for both signed and unsigned loads
    misaligned = ((funct3[1:0] == 2'd1) && addr_lo[0]) ||
                 ((funct3[1:0] == 2'd2) && (addr_lo != 2'd0));
    illegal    = we ? (funct3 > 3'd2)
                    : ((funct3 == 3'd3) || (funct3 >= 3'd6));
  end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory slave with fixed latency, byte/half/word access and error reporting.
`default_nettype none

module dmem_responder
  import dmem_pkg::*;
#(
  parameter int                AWIDTH      = 32,
  parameter int                DWIDTH      = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR   = 32'h02000000,
  parameter int                DEPTH_BYTES = 4096,
  parameter int                LATENCY     = 2
) (
  input  logic clk,
  input  logic reset,
  dmem_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_BYTES);
  localparam int WORDS = DEPTH_BYTES / 4;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                accept, commit;

  logic                we_q;
  logic [AWIDTH-1:0]   addr_q;
  logic [DWIDTH-1:0]   wdata_q;
  logic [2:0]          funct3_q;
  logic [DWIDTH-1:0]   rdata_q;
  logic                err_q;

  logic [AWIDTH-1:0]   offset;
  logic                in_range;
  logic [IDX_W-3:0]    widx;
  logic [31:0]         rword;
  logic [3:0]          byte_en;
  logic [31:0]         wdata_sh;
  logic [31:0]         load_data;
  logic                misaligned, illegal, access_err, do_write;

  assign offset     = addr_q - BASE_ADDR;
  assign in_range   = (addr_q >= BASE_ADDR) && (offset < AWIDTH'(DEPTH_BYTES));
  assign widx       = offset[IDX_W-1:2];
  assign access_err = misaligned || illegal || !in_range;
  // reset on the commit edge must suppress the write
  assign do_write   = commit && we_q && !access_err && !reset;

  dmem_lane_align u_lane_align (
    .we         (we_q),
    .addr_lo    (addr_q[1:0]),
    .funct3     (funct3_q),
    .wdata      (wdata_q),
    .rword      (rword),
    .byte_en    (byte_en),
    .wdata_sh   (wdata_sh),
    .load_data  (load_data),
    .misaligned (misaligned),
    .illegal    (illegal)
  );

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] lane_mem [WORDS];

    always_ff @(posedge clk) begin
      if (do_write && byte_en[i]) begin
        lane_mem[widx] <= wdata_sh[8*i +: 8];
      end
    end

    assign rword[8*i +: 8] = lane_mem[widx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          accept  = 1'b1;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          commit  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q     <= bus.req_we_i;
      addr_q   <= bus.req_addr_i;
      wdata_q  <= bus.req_wdata_i;
      funct3_q <= bus.req_funct3_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (commit) begin
      err_q   <= access_err;
      rdata_q <= (access_err || we_q) ? '0 : load_data;
    end
  end

  assign bus.req_ready_o = (state_q == IDLE);
  assign bus.rsp_valid_o = (state_q == RESP);
  assign bus.rsp_rdata_o = rdata_q;
  assign bus.rsp_err_o   = err_q;

endmodule

`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the core's data-memory port. It accepts load/store requests through a valid/ready handshake, models a fixed access latency, and performs byte, halfword and word accesses selected by RISC-V funct3. It returns sign- or zero-extended load data, or an error flag, through a second valid/ready handshake. It replaces the zero-latency data memory so the core's load/store path can be exercised against a real multi-cycle slave.

## Interface
- AWIDTH, 32, address width
- DWIDTH, 32, data width (fixed at 32)
- BASE_ADDR, 32'h02000000, first byte address served
- DEPTH_BYTES, 4096, bytes of storage; power of two
- LATENCY, 2, cycles from request accept to response valid; must be ≥1
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- req_valid_i  input  1  request present
- req_ready_o  output  1  responder can accept a request
- req_we_i  input  1  1 = store, 0 = load
- req_addr_i  input  AWIDTH  byte address
- req_wdata_i  input  DWIDTH  store data; the low bytes are used for SB/SH
- req_funct3_i  input  3  access size/sign (RISC-V load/store funct3)
- rsp_valid_o  output  1  response present
- rsp_ready_i  input  1  requester takes the response
- rsp_rdata_o  output  DWIDTH  load result; 0 for stores and errors
- rsp_err_o  output  1  access rejected

## Operation
- Storage is a little-endian byte array, indexed by req_addr_i − BASE_ADDR. Reset does not clear it.
- The FSM has three states: IDLE, WAIT and RESP.
  - In IDLE, req_ready_o = 1. The request is accepted when req_valid_i & req_ready_o.
  - On accept, latch we, addr, wdata and funct3, load the counter with LATENCY−1, and go to WAIT.
  - In WAIT, the counter decrements each cycle. When it is 0, perform the access and go to RESP.
  - In RESP, rsp_valid_o = 1, and rsp_rdata_o and rsp_err_o are held stable. When rsp_ready_i is high, go to IDLE.
- The following conditions produce an error. On error, no write occurs, rsp_err_o = 1 and rsp_rdata_o = 0.
  - Misaligned access: a half access with addr[0] = 1, or a word access with addr[1:0] ≠ 0.
  - Out-of-range address: addr < BASE_ADDR or addr ≥ BASE_ADDR + DEPTH_BYTES.
  - Illegal funct3: for loads, 3, 6 or 7; for stores, 3 or higher.
- Loads:
  - LB (0) and LH (1) sign-extend.
  - LW (2) returns the full word.
  - LBU (4) and LHU (5) zero-extend.
- Stores:
  - SB (0) writes wdata[7:0] at addr.
  - SH (1) writes wdata[15:0] at addr and addr+1.
  - SW (2) writes 4 bytes.
  - Other bytes are untouched.
- A store response has rsp_rdata_o = 0 and rsp_err_o = 0.
- Only one transaction is outstanding at a time. Requests presented outside IDLE are ignored (req_ready_o = 0).

## Timing
- Reset values: state IDLE, req_ready_o = 1, rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0, counter = 0.
- Request accepted at edge k:
  - The store is committed at edge k+LATENCY.
  - rsp_valid_o rises after edge k+LATENCY.
- The response is consumed at the first edge where rsp_valid_o & rsp_ready_i.
  - req_ready_o is high from the following cycle.
  - The next accept occurs no earlier than one cycle after the response handshake.
- Back-to-back throughput is one transaction per LATENCY+2 cycles when rsp_ready_i is held high.
- rsp_ready_i low: the response is held indefinitely and its outputs are unchanged.
- LATENCY = 1: WAIT lasts one cycle, with the counter at 0 on entry.
- Reset in WAIT: the access is abandoned and no write occurs. Reset on the commit edge takes priority, so no write occurs then either.
- Reset in RESP: the response is dropped. A store already committed remains in memory.

## Structure
- Shared package (dmem_pkg):
  - FUNCT3_LB/LH/LW/LBU/LHU and FUNCT3_SB/SH/SW constants.
  - State enum for {IDLE, WAIT, RESP}.
- Sub-module dmem_lane_align is combinational. From the latched address and funct3 it produces:
  - the byte-enable mask and shifted write data;
  - the extracted, extended load data;
  - the misalignment and illegal-funct3 flags.
- The top level holds the FSM, the latency counter, the byte array and the range check.

## Test plan
- SW of 32'hDEADBEEF to 32'h02000010, then LW of the same address → rsp_rdata_o = 32'hDEADBEEF, err = 0, with rsp_valid_o rising LATENCY cycles after each accept.
- After the store above, LB at 32'h02000013 → 32'hFFFFFFDE. LBU at the same address → 32'h000000DE. LH at 32'h02000010 → 32'hFFFFBEEF. LHU at the same address → 32'h0000BEEF.
- SB of 8'h55 to 32'h02000011, then LW of 32'h02000010 → 32'hDEAD55EF.
- Error cases, each with rsp_err_o = 1 and rsp_rdata_o = 0:
  - LH at 32'h02000011.
  - SW at 32'h02001000 (out of range); a following LW at 32'h02000000 is unchanged.
  - Load with funct3 = 3.
- Hold rsp_ready_i = 0 for 5 cycles → rsp_valid_o stays 1 with stable data, and req_ready_o stays 0. A new req_valid_i during the hold is not accepted.
- Assert reset one cycle into WAIT of an SW to 32'h02000020 → all outputs return to reset values, and a later LW of 32'h02000020 returns the prior contents.
